fix2float32_pipe: RTL and testbench

//  Converts a signed two's-complement Q(NUM_OF_INT).(NUM_OF_FRAC) fixed-point value back to IEEE-754 FP32.

---
 rtl/fp32_pkg.sv | 13 +
 rtl/lzd_fix.sv | 15 +
 rtl/fix2float32_pipe.sv | 91 +++++++++
 tb/tb_fix2float32_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: FP32 field widths and special encodings shared by the fixed<->float converters
package fp32_pkg;
  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/lzd_fix.sv
// lzd_fix: position of the most significant set bit plus an all-zero flag
module lzd_fix #(
  parameter int W  = 31,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] pos,
  output logic          zero
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) if (vec[i]) pos = PW'(i);
  end
  assign zero = ~|vec;
endmodule

// File: rtl/fix2float32_pipe.sv
// fix2float32_pipe: signed Q(NUM_OF_INT).(NUM_OF_FRAC) to FP32, 3-stage valid/ready pipeline
module fix2float32_pipe
  import fp32_pkg::*;
#(
  parameter int NUM_OF_INT  = 8,
  parameter int NUM_OF_FRAC = 23
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [NUM_OF_INT-1:0]  IN_int,
  input  logic [NUM_OF_FRAC-1:0] IN_frac,
  input  logic                   IN_overflow,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [31:0]            OUT_FLOAT32
);
  localparam int W  = NUM_OF_INT + NUM_OF_FRAC;
  localparam int PW = $clog2(W);
  logic en;
  logic [W-1:0] raw, mag_c;
  logic s1_v, s1_sign, s1_ovf;
  logic [W-1:0] s1_mag;
  logic [PW-1:0] p;
  logic zero_c;
  logic [W-2:0] norm_c;
  logic [FP32_EXP_W-1:0] exp_c;
  logic s2_v, s2_sign, s2_ovf, s2_zero;
  logic [FP32_EXP_W-1:0] s2_exp;
  logic [W-2:0] s2_norm;
  logic [W+22:0] normx;
  logic [FP32_MAN_W-1:0] frac_k, frac_r;
  logic guard, sticky, rnd, carry;
  fp32_t res;
  assign en       = !OUT_VALID | OUT_READY;
  assign IN_READY = en;
  assign raw      = {IN_int, IN_frac};
  assign mag_c    = raw[W-1] ? -raw : raw;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_ovf  <= 1'b0;
      s1_mag  <= '0;
    end else if (en) begin
      s1_v    <= IN_VALID;
      s1_sign <= raw[W-1];
      s1_ovf  <= IN_overflow;
      s1_mag  <= mag_c;
    end
  end
  lzd_fix #(.W(W), .PW(PW)) u_lzd (.vec(s1_mag), .pos(p), .zero(zero_c));
  // Leading one is implicit after normalisation, so only the bits below it are kept
  assign norm_c = (W-1)'(s1_mag << (PW'(W - 1) - p));
  assign exp_c  = FP32_EXP_W'(32'(p) + FP32_BIAS - NUM_OF_FRAC);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_ovf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= '0;
      s2_norm <= '0;
    end else if (en) begin
      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_ovf  <= s1_ovf;
      s2_zero <= zero_c;
      s2_exp  <= exp_c;
      s2_norm <= norm_c;
    end
  end
  // Zero padding makes guard/sticky vanish when fewer than 24 significant bits exist
  assign normx           = {s2_norm, 24'b0};
  assign frac_k          = normx[W+22:W];
  assign guard           = normx[W-1];
  assign sticky          = |normx[W-2:0];
  assign rnd             = guard & (sticky | frac_k[0]);
  assign {carry, frac_r} = {1'b0, frac_k} + 24'(rnd);
  assign res             = '{sign: s2_sign, exp: s2_exp + FP32_EXP_W'(carry), man: frac_r};
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID   <= 1'b0;
      OUT_FLOAT32 <= '0;
    end else if (en) begin
      OUT_VALID <= s2_v;
      if (s2_v) OUT_FLOAT32 <= s2_ovf ? (s2_sign ? FP32_NEG_INF : FP32_POS_INF) : s2_zero ? 32'h0 : res;
    end
  end
endmodule

// File: tb/tb_fix2float32_pipe.sv
// tb_fix2float32_pipe: directed and randomized checks of fix2float32_pipe against an arithmetic model
module tb_fix2float32_pipe;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID, IN_READY, IN_overflow;
  logic [7:0]  IN_int;
  logic [22:0] IN_frac;
  logic        OUT_VALID, OUT_READY;
  logic [31:0] OUT_FLOAT32;
  int total = 0;
  int bad = 0;
  int sent, got;
  logic [31:0] q[$];
  logic [30:0] bp[6];

  fix2float32_pipe #(.NUM_OF_INT(8), .NUM_OF_FRAC(23)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_int(IN_int), .IN_frac(IN_frac), .IN_overflow(IN_overflow),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_FLOAT32(OUT_FLOAT32)
  );

  always #5 CLK = ~CLK;

  // Value = signed word / 2^23; round magnitude to 24 significant bits with ties to even
  function automatic logic [31:0] model(input logic [7:0] i, input logic [22:0] f, input logic o);
    logic signed [30:0] r;
    longint v, m, qq, rem, half;
    int e, sh;
    logic s;
    r = {i, f};
    v = r;
    s = v < 0;
    m = s ? -v : v;
    if (o) return s ? 32'hFF80_0000 : 32'h7F80_0000;
    if (m == 0) return 32'h0;
    e = 0;
    while ((longint'(1) << (e + 1)) <= m) e++;
    if (e <= 23) qq = m << (23 - e);
    else begin
      sh = e - 23;
      qq = m >> sh;
      rem = m - (qq << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && qq[0])) qq++;
      if (qq == (longint'(1) << 24)) begin
        qq = qq >> 1;
        e++;
      end
    end
    return {s, 8'(e + 104), qq[22:0]};
  endfunction

  task automatic tick(input logic chk_stall);
    logic [31:0] want;
    @(negedge CLK);
    if (chk_stall) begin
      total++;
      assert (IN_READY === 1'b0) else begin bad++; $error("FAIL stall_in_ready got=%0b exp=0", IN_READY); end
      total++;
      assert (OUT_VALID === 1'b1 && q.size() > 0 && OUT_FLOAT32 === q[0])
        else begin bad++; $error("FAIL stall_hold got=%h exp=%h", OUT_FLOAT32, (q.size() > 0) ? q[0] : 32'hx); end
    end
    if (OUT_VALID && OUT_READY) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $error("FAIL unexpected_out got=%h exp=none", OUT_FLOAT32);
      end else begin
        want = q.pop_front();
        got++;
        assert (OUT_FLOAT32 === want) else begin bad++; $error("FAIL data got=%h exp=%h", OUT_FLOAT32, want); end
      end
    end
    if (IN_VALID && IN_READY) begin
      q.push_back(model(IN_int, IN_frac, IN_overflow));
      sent++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic one(input logic [7:0] i, input logic [22:0] f, input logic o, input logic [31:0] want, input string tag);
    int n;
    IN_VALID = 1'b1; IN_int = i; IN_frac = f; IN_overflow = o; OUT_READY = 1'b1;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!OUT_VALID && n < 10);
    total++;
    assert (n === 3) else begin bad++; $error("FAIL %s_latency got=%0d exp=3", tag, n); end
    total++;
    assert (OUT_FLOAT32 === want) else begin bad++; $error("FAIL %s got=%h exp=%h", tag, OUT_FLOAT32, want); end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_int = '0; IN_frac = '0; IN_overflow = 1'b0;
    #1;
    total++;
    assert (OUT_VALID === 1'b0) else begin bad++; $error("FAIL reset_valid got=%b exp=0", OUT_VALID); end
    total++;
    assert (OUT_FLOAT32 === 32'h0) else begin bad++; $error("FAIL reset_data got=%h exp=0", OUT_FLOAT32); end
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    one(8'h01, 23'h0,      1'b0, 32'h3F80_0000, "one");
    one(8'hFF, 23'h0,      1'b0, 32'hBF80_0000, "minus_one");
    one(8'h80, 23'h0,      1'b0, 32'hC300_0000, "most_neg");
    one(8'h40, 23'h20,     1'b0, 32'h4280_0000, "tie_even_down");
    one(8'h40, 23'h60,     1'b0, 32'h4280_0002, "tie_up");
    one(8'h7F, 23'h7FFFFF, 1'b0, 32'h4300_0000, "carry_exp");
    one(8'h00, 23'h0,      1'b0, 32'h0000_0000, "zero");
    one(8'h00, 23'h1,      1'b0, 32'h3400_0000, "min_pos");
    one(8'h00, 23'h0,      1'b1, 32'h7F80_0000, "pos_inf");
    one(8'hFF, 23'h0,      1'b1, 32'hFF80_0000, "neg_inf");
    one(8'hFF, 23'h7FFFFF, 1'b0, 32'hB400_0000, "min_neg");
    for (int k = 0; k < 6; k++) bp[k] = 31'($urandom);
    q.delete(); sent = 0; got = 0;
    for (int c = 0; c < 24; c++) begin
      IN_VALID = sent < 6;
      if (sent < 6) {IN_int, IN_frac} = bp[sent];
      IN_overflow = 1'b0;
      OUT_READY = !(c >= 4 && c < 8);
      tick(c >= 4 && c < 8);
    end
    total++;
    assert (got === 6 && q.size() === 0) else begin bad++; $error("FAIL bp_count got=%0d exp=6 left=%0d", got, q.size()); end
    q.delete(); sent = 0; got = 0;
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1;
      {IN_int, IN_frac} = 31'($urandom);
      IN_overflow = 1'b0;
      tick(1'b0);
    end
    IN_VALID = 1'b0;
    total++;
    assert (OUT_VALID === 1'b1) else begin bad++; $error("FAIL inflight_valid got=%b exp=1", OUT_VALID); end
    RST_N = 1'b0;
    #1;
    total++;
    assert (OUT_VALID === 1'b0) else begin bad++; $error("FAIL async_reset got=%b exp=0", OUT_VALID); end
    q.delete();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      total++;
      assert (OUT_VALID === 1'b0) else begin bad++; $error("FAIL stale_after_reset got=%b exp=0", OUT_VALID); end
      @(posedge CLK);
      #1;
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      IN_VALID = $urandom_range(0, 3) != 0;
      OUT_READY = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 7))
        0: {IN_int, IN_frac} = 31'h4000_0000;
        1: {IN_int, IN_frac} = 31'($urandom_range(0, 255));
        2: {IN_int, IN_frac} = 31'h0;
        default: {IN_int, IN_frac} = 31'($urandom);
      endcase
      IN_overflow = $urandom_range(0, 15) == 0;
      tick(1'b0);
    end
    total++;
    assert (sent === 10000) else begin bad++; $error("FAIL rand_budget got=%0d exp=10000", sent); end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (6) tick(1'b0);
    total++;
    assert (got === sent && q.size() === 0) else begin bad++; $error("FAIL rand_drain got=%0d exp=%0d", got, sent); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
